lipsi_src_mux: RTL and testbench
================================

LIPSI_SRC_MUX -- requirements
Module: lipsi_src_mux

Interface
REQ-001 SHALL provide parameter W, default 8: base data width; output is W+1 bits (carry bit on top).
REQ-002 SHALL provide parameter NCH, default 3, legal range 2..16: number of source channels.
REQ-003 SHALL provide parameter MODE, default 0: 0 = explicit select, 1 = round-robin among valid channels.
REQ-004 SHALL provide parameter CARRY_MASK, NCH bits, default 3'b100: bit i = 1 means channel i drives its own MSB; bit i = 0 means that MSB is forced to 0 (zero-extend).
REQ-005 SHALL define CW = max(1, clog2(NCH)) for internal use.
REQ-006 Ports, in order:
  clk  in  1  clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  in_data  in  NCH*(W+1)  packed channel data, channel i at [i*(W+1) +: W+1]
  in_valid  in  NCH  per-channel data valid
  in_ready  out  NCH  per-channel accept
  sel  in  CW  channel select, used when MODE=0
  out_data  out  W+1  registered selected data
  out_ch  out  CW  index of channel held in out_data
  out_valid  out  1  output register occupied
  out_ready  in  1  downstream accept
  err_sel  out  1  sticky illegal-select flag
  err_clr  in  1  clears err_sel
REQ-007 SHALL have one clock; reset is asynchronous and active-low.

Function
REQ-008 SHALL compute the grant combinationally: MODE=0 grants channel sel when sel < NCH; MODE=1 grants the first valid channel searching upward from rr_ptr+1 with wrap-around.
REQ-009 SHALL define open = !out_valid || out_ready; load = open && grant exists && in_valid[grant].
REQ-010 SHALL drive in_ready[i] = 1 only for i == grant and only when open; all other bits 0.
REQ-011 SHALL, on load, capture the granted channel's data, with the MSB forced to 0 where CARRY_MASK[i]=0, into out_data, capture its index into out_ch, and set out_valid -- one-cycle latency from acceptance to out_valid.
REQ-012 SHALL clear out_valid when out_ready=1 and load=0; SHALL hold out_data and out_ch unchanged while out_valid=1 and out_ready=0.
REQ-013 SHALL sustain one transfer per cycle: out_ready=1 and load=1 in the same cycle replaces the register with no bubble.
REQ-014 SHALL ignore sel and in_data changes during a stall; the registered output is not disturbed.
REQ-015 SHALL, in MODE=1, update rr_ptr to the granted index only on load; with no valid channel, no grant and rr_ptr holds.
REQ-016 SHALL, in MODE=0 with sel >= NCH, make no grant: all in_ready=0 and no load.
REQ-017 SHALL set err_sel on any clock edge where MODE=0 and sel >= NCH; err_sel stays set until err_clr=1, and set wins over simultaneous clear.
REQ-018 SHALL tie err_sel to 0 in MODE=1.

Reset
REQ-019 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_ch=0, err_sel=0, rr_ptr=NCH-1 (first round-robin grant = channel 0), and in_ready=0, taking effect immediately regardless of clk.
REQ-020 SHALL discard any held output on reset mid-transfer; the first load after release behaves as from idle.

Verification
REQ-021 MODE=0, W=8, NCH=3: sel=1, ch1=8'hA5, ch2=9'h1FF, in_valid=3'b111, out_ready=1 -> next cycle out_data=9'h0A5, out_ch=1; then sel=2 -> out_data=9'h1FF, out_ch=2.
REQ-022 Stall: out_valid=1, out_ready=0 for 3 cycles while sel and in_data toggle -> out_data/out_ch constant, in_ready=0; out_ready=1 with a new valid source -> back-to-back update, no bubble.
REQ-023 MODE=0: sel=3 for one cycle -> in_ready=0, no load, err_sel=1 and held; err_clr=1 with sel=3 -> err_sel stays 1; err_clr=1 with sel=0 -> err_sel=0 next cycle.
REQ-024 MODE=1: all channels valid, out_ready=1 -> grant order 0,1,2,0,...; only channel 2 valid -> grant 2 every cycle; no channel valid -> out_valid drops after drain.
REQ-025 Assert rst_n=0 mid-clock while out_valid=1 -> out_valid, out_data, err_sel = 0 immediately; after release, first MODE=1 grant is channel 0.

Source files
------------

// File: rtl/lipsi_src_mux.sv
// lipsi_src_mux
//   Selects one of NCH source channels and registers its data into a single
//   output stage with valid/ready handshaking.
//   MODE=0: explicit channel select via sel (illegal sel raises sticky err_sel).
//   MODE=1: round-robin among valid channels, starting after the last grant.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    NCH packed channels of W+1 bits, channel i at [i*(W+1) +: W+1]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept (only the granted channel, only when open)
//   sel        channel select (MODE=0 only)
//   out_data   registered selected data (carry bit on top)
//   out_ch     index of the channel held in out_data
//   out_valid  output register occupied
//   out_ready  downstream accept
//   err_sel    sticky illegal-select flag (always 0 in MODE=1)
//   err_clr    clears err_sel
module lipsi_src_mux #(
    parameter int W = 8,
    parameter int NCH = 3,
    parameter int MODE = 0,
    // Default gives only the top channel its own carry bit (3'b100 for NCH=3).
    parameter logic [NCH-1:0] CARRY_MASK = {{(NCH-1){1'b0}}, 1'b1} << (NCH-1),
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*(W+1)-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [CW-1:0]        sel,
    output logic [W:0]           out_data,
    output logic [CW-1:0]        out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_sel,
    input  logic                 err_clr
);

    logic [W:0]    chan_data [NCH];
    logic [CW-1:0] rr_ptr_reg;
    logic          grant_ok;
    logic [CW-1:0] grant_idx;
    logic [W:0]    grant_data;
    logic          open;
    logic          load;
    logic          sel_bad;

    // Per-channel data with the carry bit zero-extended where the mask says so.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign chan_data[gi] = {in_data[gi*(W+1)+W] & CARRY_MASK[gi],
                                    in_data[gi*(W+1) +: W]};
        end
    endgenerate

    assign sel_bad = (MODE == 0) && (int'(sel) >= NCH);

    // Grant selection. Round-robin looks for the lowest valid index above
    // rr_ptr first; failing that, the lowest valid index at or below it
    // (wrap-around). Loops run downward so the lowest match is written last.
    always_comb begin
        logic          found_hi;
        logic          found_lo;
        logic [CW-1:0] hi_idx;
        logic [CW-1:0] lo_idx;
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        grant_ok  = 1'b0;
        grant_idx = '0;
        if (MODE == 0) begin
            if (!sel_bad) begin
                grant_ok  = 1'b1;
                grant_idx = sel;
            end
        end else begin
            for (int j = NCH - 1; j >= 0; j--) begin
                if (in_valid[j]) begin
                    if (j > int'(rr_ptr_reg)) begin
                        found_hi = 1'b1;
                        hi_idx   = CW'(j);
                    end else begin
                        found_lo = 1'b1;
                        lo_idx   = CW'(j);
                    end
                end
            end
            grant_ok  = found_hi || found_lo;
            grant_idx = found_hi ? hi_idx : lo_idx;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int j = 0; j < NCH; j++) begin
            if (CW'(j) == grant_idx) begin
                grant_data = chan_data[j];
            end
        end
    end

    assign open = !out_valid || out_ready;

    // in_ready is gated by rst_n so it drops immediately on reset assertion.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
            assign in_ready[gi] = rst_n && open && grant_ok && (grant_idx == CW'(gi));
        end
    endgenerate

    assign load = |(in_ready & in_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            rr_ptr_reg <= CW'(NCH - 1);
        end else begin
            if (load) begin
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                out_valid <= 1'b1;
                if (MODE == 1) begin
                    rr_ptr_reg <= grant_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sticky error: a bad select on the same edge as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel <= 1'b0;
        end else if (sel_bad) begin
            err_sel <= 1'b1;
        end else if (err_clr) begin
            err_sel <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lipsi_src_mux.sv
module tb_lipsi_src_mux;

    localparam int W = 8;
    localparam int NCH = 3;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT0: explicit select
    logic [NCH*(W+1)-1:0] in_data0 = '0;
    logic [NCH-1:0]       in_valid0 = '0;
    logic [NCH-1:0]       in_ready0;
    logic [CW-1:0]        sel0 = '0;
    logic [W:0]           out_data0;
    logic [CW-1:0]        out_ch0;
    logic                 out_valid0;
    logic                 out_ready0 = 1'b1;
    logic                 err_sel0;
    logic                 err_clr0 = 1'b0;

    // DUT1: round-robin
    logic [NCH*(W+1)-1:0] in_data1 = '0;
    logic [NCH-1:0]       in_valid1 = '0;
    logic [NCH-1:0]       in_ready1;
    logic [CW-1:0]        sel1 = '0;
    logic [W:0]           out_data1;
    logic [CW-1:0]        out_ch1;
    logic                 out_valid1;
    logic                 out_ready1 = 1'b1;
    logic                 err_sel1;
    logic                 err_clr1 = 1'b0;

    lipsi_src_mux #(.W(W), .NCH(NCH), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .sel(sel0), .out_data(out_data0), .out_ch(out_ch0),
        .out_valid(out_valid0), .out_ready(out_ready0), .err_sel(err_sel0),
        .err_clr(err_clr0)
    );

    lipsi_src_mux #(.W(W), .NCH(NCH), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .sel(sel1), .out_data(out_data1), .out_ch(out_ch1),
        .out_valid(out_valid1), .out_ready(out_ready1), .err_sel(err_sel1),
        .err_clr(err_clr1)
    );

    int tests = 0;
    int fails = 0;

    // Expected entries: {data, channel}
    logic [W+CW:0] q0 [$];
    logic [W+CW:0] q1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: an output is consumed at the next posedge when valid && ready.
    always @(negedge clk) begin
        if (rst_n && out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected output", {21'd0, out_ch0, out_data0}, 32'hFFFF_FFFF);
            end else begin
                logic [W+CW:0] e;
                e = q0.pop_front();
                check("dut0 out_data", 32'(out_data0), 32'(e[W:0]));
                check("dut0 out_ch", 32'(out_ch0), 32'(e[W+CW:W+1]));
            end
        end
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected output", {21'd0, out_ch1, out_data1}, 32'hFFFF_FFFF);
            end else begin
                logic [W+CW:0] e;
                e = q1.pop_front();
                check("dut1 out_data", 32'(out_data1), 32'(e[W:0]));
                check("dut1 out_ch", 32'(out_ch1), 32'(e[W+CW:W+1]));
            end
        end
    end

    initial begin
        // ch2=1FF, ch1=0A5, ch0=133 (carry masked -> 033)
        in_data0 = {9'h1FF, 9'h0A5, 9'h133};
        // ch2=122, ch1=111 (masked -> 011), ch0=044
        in_data1 = {9'h122, 9'h111, 9'h044};
        #12;
        check("reset out_valid0", 32'(out_valid0), 0);
        check("reset out_data0", 32'(out_data0), 0);
        check("reset err_sel0", 32'(err_sel0), 0);
        check("reset in_ready0", 32'(in_ready0), 0);
        check("reset out_valid1", 32'(out_valid1), 0);
        step();
        rst_n = 1'b1;

        // ---- explicit select ----
        sel0 = 2'd1; in_valid0 = 3'b111; out_ready0 = 1'b1;
        q0.push_back({2'd1, 9'h0A5});
        step();
        sel0 = 2'd2; q0.push_back({2'd2, 9'h1FF});
        step();
        sel0 = 2'd0; q0.push_back({2'd0, 9'h033});
        step();
        sel0 = 2'd1; q0.push_back({2'd1, 9'h0A5});
        step();
        // stall with toggling sel and data
        out_ready0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel0 = (i % 2 == 0) ? 2'd2 : 2'd0;
            in_data0 = (i % 2 == 0) ? {9'h0AA, 9'h055, 9'h1EE} : {9'h1FF, 9'h0A5, 9'h133};
            #1;
            check("stall in_ready0", 32'(in_ready0), 0);
            step();
            check("stall out_data0", 32'(out_data0), 32'h0A5);
            check("stall out_ch0", 32'(out_ch0), 1);
        end
        in_data0 = {9'h1C3, 9'h0A5, 9'h133};
        sel0 = 2'd2; out_ready0 = 1'b1;
        q0.push_back({2'd2, 9'h1C3});
        #1;
        check("release in_ready0", 32'(in_ready0), 32'b100);
        step();
        check("no bubble out_valid0", 32'(out_valid0), 1);
        in_valid0 = 3'b000;
        step();
        check("drain out_valid0", 32'(out_valid0), 0);

        // illegal select
        sel0 = 2'd3; in_valid0 = 3'b111;
        #1;
        check("bad sel in_ready0", 32'(in_ready0), 0);
        step();
        check("bad sel err_sel0", 32'(err_sel0), 1);
        check("bad sel no load", 32'(out_valid0), 0);
        sel0 = 2'd0; in_valid0 = 3'b000;
        step();
        check("err_sel0 held", 32'(err_sel0), 1);
        sel0 = 2'd3; err_clr0 = 1'b1;
        step();
        check("err set wins clear", 32'(err_sel0), 1);
        sel0 = 2'd0;
        step();
        check("err cleared", 32'(err_sel0), 0);
        err_clr0 = 1'b0;

        // ---- round-robin ----
        in_valid1 = 3'b111; out_ready1 = 1'b1;
        q1.push_back({2'd0, 9'h044});
        q1.push_back({2'd1, 9'h011});
        q1.push_back({2'd2, 9'h122});
        q1.push_back({2'd0, 9'h044});
        repeat (4) step();
        in_valid1 = 3'b100;
        repeat (3) begin
            q1.push_back({2'd2, 9'h122});
            step();
        end
        in_valid1 = 3'b000;
        step();
        check("rr drain out_valid1", 32'(out_valid1), 0);

        // ---- reset mid-transfer ----
        sel0 = 2'd1; in_valid0 = 3'b111; out_ready0 = 1'b0;
        in_valid1 = 3'b010; out_ready1 = 1'b0;
        step();
        sel0 = 2'd3; in_valid1 = 3'b000;
        step();
        check("pre-reset err_sel0", 32'(err_sel0), 1);
        check("pre-reset out_valid1", 32'(out_valid1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid0", 32'(out_valid0), 0);
        check("async rst out_data0", 32'(out_data0), 0);
        check("async rst err_sel0", 32'(err_sel0), 0);
        check("async rst out_valid1", 32'(out_valid1), 0);
        check("async rst out_data1", 32'(out_data1), 0);
        sel0 = 2'd0; in_valid0 = 3'b000;
        in_valid1 = 3'b111; out_ready1 = 1'b1;
        #1;
        check("rst in_ready1", 32'(in_ready1), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        q1.push_back({2'd0, 9'h044});
        step();
        in_valid1 = 3'b000;
        step();
        step();
        check("q0 drained", 32'(q0.size()), 0);
        check("q1 drained", 32'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
